pointing_device_serializer: RTL

Parametrised successor to the CD-i pointing-device transmitter. Merges mouse, digital D-pad and analog stick into per-axis relative motion accumulators with saturation and residue carry, and serialises 3-byte CD-i pointer packets onto a `bytestream` source at a configurable byte rate. It sits between the MiSTer HPS input buses and the UART model feeding the SLAVE processor. Unlike its predecessor, it accumulates mouse motion instead of sampling it, so no deltas are lost between packet slots.

---
 rtl/pointing_device_serializer_pkg.sv | 14 +
 rtl/pointing_device_serializer_if.sv | 10 +
 rtl/pointing_device_serializer_axis.sv | 39 +++
 rtl/pointing_device_serializer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pointing_device_serializer_pkg.sv
// pointing_pkg: state encoding, CD-i device ID bytes and the 8-bit clamp
// shared by the pointer serializer and its axis accumulators.
package pointing_pkg;

    typedef enum logic [1:0] {ID, B0, B1, B2} e_ptr_state;

    localparam logic [7:0] PTR_ID_MANEUVER = 8'hCA;
    localparam logic [7:0] PTR_ID_RELATIVE = 8'hCD;

    function automatic logic signed [7:0] sat_s8(input logic signed [15:0] v);
        return (v > 16'sd127) ? 8'h7F : (v < -16'sd128) ? 8'h80 : v[7:0];
    endfunction

endpackage

// File: rtl/pointing_device_serializer_if.sv
// bytestream: one-cycle write strobe with an 8-bit byte, no backpressure.
interface bytestream;

    logic       write;
    logic [7:0] data;

    modport source (output write, data);
    modport sink   (input  write, data);

endinterface

// File: rtl/pointing_device_serializer_axis.sv
// pointer_axis_accumulator: one axis of saturating relative motion with
// packet latch, residue carry and clear.
module pointer_axis_accumulator
    import pointing_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              ev,
    input  logic signed [9:0] delta,
    input  logic signed [7:0] joy,
    input  logic              take,
    output logic signed [7:0] d
);

    localparam int W = ACC_W + 2;
    localparam logic signed [W-1:0] LIM  = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [W-1:0] NLIM = -LIM;

    logic signed [ACC_W-1:0] acc, acc_n;
    logic signed [W-1:0]     t, nxt;

    // t carries the joystick on top of the stored motion; whatever the 8-bit
    // packet cannot hold stays behind as residue for the next packet.
    always_comb begin
        t     = {{2{acc[ACC_W-1]}}, acc} + {{(W-8){joy[7]}}, joy};
        d     = sat_s8({{(16-W){t[W-1]}}, t});
        nxt   = (take ? t - {{(W-8){d[7]}}, d} : {{2{acc[ACC_W-1]}}, acc})
              + (ev ? {{(W-10){delta[9]}}, delta} : '0);
        acc_n = (nxt > LIM) ? LIM[ACC_W-1:0] : (nxt < NLIM) ? NLIM[ACC_W-1:0] : nxt[ACC_W-1:0];
    end

    always_ff @(posedge clk)
        if (!reset_n || clr) acc <= '0;
        else acc <= acc_n;

endmodule

// File: rtl/pointing_device_serializer.sv
// pointing_device_serializer: merges mouse, D-pad and analog stick into
// relative motion and emits 3-byte CD-i pointer packets at a fixed byte rate.
module pointing_device_serializer
    import pointing_pkg::*;
#(
    parameter int         TICKS_NORMAL  = 250000,
    parameter int         TICKS_OC      = 200000,
    parameter logic [7:0] DEVICE_ID     = PTR_ID_RELATIVE,
    parameter int         ACC_W         = 10,
    parameter int         SPEED_SLOW    = 2,
    parameter int         SPEED_FAST    = 8,
    parameter int         SPEED_FAST_OC = 7,
    parameter int         ACCEL_THRESH  = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mister_joystick,
    input  logic [15:0] mister_joystick_analog,
    input  logic [24:0] mister_mouse,
    input  logic        rts,
    input  logic        overclock,
    bytestream.source   serial_out
);

    e_ptr_state        state;
    logic [31:0]       cnt, tick;
    logic [2:0]        accel;
    logic [1:0]        last_b;
    logic [7:0]        byte1, byte2, data;
    logic              write, mouse_tog, ev, b1, b2, send, take;
    logic [7:0]        speed, dpad_x, dpad_y, ana_x, ana_y, joy_x, joy_y;
    logic signed [7:0] dx, dy;
    logic signed [9:0] mdx, mdy;
    logic              unused_bits;

    function automatic logic [7:0] ana(input logic [7:0] a);
        logic signed [8:0] s;
        s = ($signed({a[7], a}) + 9'sd4) >>> 3;
        return 8'(s);
    endfunction

    assign unused_bits = ^{mister_joystick[15:6], mister_mouse[7:6], mister_mouse[3:2]};

    always_comb begin
        tick   = overclock ? TICKS_OC : TICKS_NORMAL;
        ev     = mister_mouse[24] ^ mouse_tog;
        mdx    = {mister_mouse[4], mister_mouse[4], mister_mouse[15:8]};
        mdy    = -{mister_mouse[5], mister_mouse[5], mister_mouse[23:16]};
        b1     = mister_mouse[0] | mister_joystick[5];
        b2     = mister_mouse[1] | mister_joystick[4];
        speed  = 8'((32'(accel) >= ACCEL_THRESH) ? (overclock ? SPEED_FAST_OC : SPEED_FAST) : SPEED_SLOW);
        dpad_x = mister_joystick[1] ? -speed : mister_joystick[0] ? speed : 8'd0;
        dpad_y = mister_joystick[3] ? -speed : mister_joystick[2] ? speed : 8'd0;
        ana_x  = ana(mister_joystick_analog[7:0]);
        ana_y  = ana(mister_joystick_analog[15:8]);
        joy_x  = (ana_x != 8'd0) ? ana_x : dpad_x;
        joy_y  = (ana_y != 8'd0) ? ana_y : dpad_y;
        send   = (dx != 8'sd0) || (dy != 8'sd0) || ({b1, b2} != last_b);
        take   = !rts && (cnt == 0) && (state == B0) && send;
    end

    pointer_axis_accumulator #(.ACC_W(ACC_W)) u_axis_x (
        .clk(clk), .reset_n(reset_n), .clr(rts), .ev(ev), .delta(mdx),
        .joy(joy_x), .take(take), .d(dx)
    );

    pointer_axis_accumulator #(.ACC_W(ACC_W)) u_axis_y (
        .clk(clk), .reset_n(reset_n), .clr(rts), .ev(ev), .delta(mdy),
        .joy(joy_y), .take(take), .d(dy)
    );

    // The toggle copy follows the input even in reset so release never fakes an event.
    always_ff @(posedge clk) begin
        mouse_tog <= mister_mouse[24];
        if (!reset_n) begin
            write  <= 1'b0;
            data   <= 8'd0;
            state  <= ID;
            cnt    <= 32'(TICKS_NORMAL);
            accel  <= 3'd0;
            last_b <= 2'b00;
            byte1  <= 8'd0;
            byte2  <= 8'd0;
        end else begin
            write <= 1'b0;
            if (rts) begin
                state  <= ID;
                cnt    <= tick;
                accel  <= 3'd0;
                last_b <= 2'b00;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
            end else begin
                cnt <= tick;
                case (state)
                    ID: begin
                        write <= 1'b1;
                        data  <= DEVICE_ID;
                        state <= B0;
                    end
                    B0: begin
                        accel <= (|mister_joystick[3:0]) ? ((accel == 3'd7) ? accel : accel + 3'd1) : 3'd0;
                        if (send) begin
                            write  <= 1'b1;
                            data   <= {2'b11, b1, b2, dy[7:6], dx[7:6]};
                            byte1  <= {2'b10, dx[5:0]};
                            byte2  <= {2'b10, dy[5:0]};
                            last_b <= {b1, b2};
                            state  <= B1;
                        end
                    end
                    B1: begin
                        write <= 1'b1;
                        data  <= byte1;
                        state <= B2;
                    end
                    default: begin
                        write <= 1'b1;
                        data  <= byte2;
                        state <= B0;
                    end
                endcase
            end
        end
    end

    assign serial_out.write = write;
    assign serial_out.data  = data;

endmodule
